// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs
// Purpose  : Generic inter-stage pipeline register with a valid/ready
//            handshake, synchronous flush and an optional 2-entry skid buffer.
//            The payload is split into a control field, zeroed whenever the
//            stage shows a bubble, and a data field, which simply holds.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   PIPE_STAGE_HS_SKID_EN  defined   -> main register M plus skid register S;
//                                       in_ready is a flop output (!S.valid).
//                          undefined -> single entry M; in_ready is
//                                       combinational from out_ready.
// ----------------------------------------------------------------------------
// Ports:
//   clock      in   1       rising-edge clock
//   reset      in   1       asynchronous active-low reset
//   flush      in   1       synchronous flush, discards all held entries
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage accepts an entry this cycle
//   in_ctrl    in   CTRL_W  upstream control field
//   in_data    in   DATA_W  upstream data field
//   out_valid  out  1       held entry valid
//   out_ready  in   1       downstream accepts the entry this cycle
//   out_ctrl   out  CTRL_W  control field, zero when out_valid=0
//   out_data   out  DATA_W  data field, holds last value when out_valid=0
//   occupancy  out  2       number of held entries
// ============================================================================
module pipe_stage_hs #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 101
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main register M: always the entry presented downstream.
    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;

    logic w_in_xfer;
    logic w_m_load;

    assign w_in_xfer = in_valid & in_ready;
    // M may take a new entry when it is empty or its entry leaves this cycle.
    assign w_m_load  = ~m_valid_q | out_ready;

`ifdef PIPE_STAGE_HS_SKID_EN
    // Skid register S catches the entry accepted while M is stalled, so that
    // in_ready can come straight from a flop.
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic              in_ready_q, in_ready_d;

    // flush only gates the registered ready; out_ready never reaches in_ready.
    assign in_ready = in_ready_q & ~flush;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (w_m_load) begin
            if (s_valid_q) begin
                // S is older than anything upstream; in_ready is low while
                // S is full, so no input can arrive in this cycle.
                m_valid_d = 1'b1;
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (w_in_xfer) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl;
                m_data_d  = in_data;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (w_in_xfer) begin
            // M stalled: park the new entry in S.
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl;
            s_data_d  = in_data;
        end
        in_ready_d = ~s_valid_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_valid_q  <= 1'b0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            s_valid_q  <= s_valid_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
`else
    assign in_ready = reset & ~flush & w_m_load;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (w_m_load) begin
            m_valid_d = w_in_xfer;
            if (w_in_xfer) begin
                m_ctrl_d = in_ctrl;
                m_data_d = in_data;
            end
        end
    end

    assign occupancy = {1'b0, m_valid_q};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
        end
    end

    // Bubbles must never carry live write enables downstream.
    assign out_valid = m_valid_q;
    assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_hs
// Purpose  : Self-checking bench for pipe_stage_hs. A queue-based FIFO model
//            of capacity 1 (or 2 with PIPE_STAGE_HS_SKID_EN) predicts every
//            cycle's handshake and outputs; a sequence scoreboard checks the
//            random stream for loss, duplication and ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 101;
    localparam int VEC_W  = 1 + 1 + CTRL_W + DATA_W + 2;
`ifdef PIPE_STAGE_HS_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = SKID ? 2 : 1;

    typedef logic [CTRL_W+DATA_W-1:0] ent_t;

    logic              clock;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    pipe_stage_hs #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    ent_t              mq[$];
    bit                started;
    logic [DATA_W-1:0] shown;
    // Per-cycle samples taken just before the edge
    logic              act_ir, act_ov, exp_ir;
    logic [DATA_W-1:0] act_od;
    int                checks, fails;

    // Acceptance rule: capacity-limited FIFO; with the skid buffer ready is
    // only known one edge after reset release and ignores out_ready.
    function automatic logic model_ir();
        if (!reset || flush) return 1'b0;
        if (SKID) return started && (mq.size() < 2);
        return (mq.size() == 0) || out_ready;
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec();
        logic [CTRL_W-1:0] c;
        logic              v;
        v = (mq.size() > 0);
        c = '0;
        if (v) c = mq[0][CTRL_W+DATA_W-1:DATA_W];
        return {exp_ir, v, c, shown, 2'(mq.size())};
    endfunction

    function automatic logic [VEC_W-1:0] act_vec();
        return {act_ir, out_valid, out_ctrl, out_data, occupancy};
    endfunction

    function automatic void model_reset();
        mq.delete();
        started = 1'b0;
        shown   = '0;
    endfunction

    // One clock: sample pre-edge, advance the model at the edge, settle.
    task automatic tick();
        bit push;
        #1;
        act_ir = in_ready;
        act_ov = out_valid;
        act_od = out_data;
        exp_ir = model_ir();
        @(posedge clock);
        if (reset) begin
            push = in_valid && exp_ir;
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (push) mq.push_back({in_ctrl, in_data});
            end
            if (mq.size() > 0) shown = mq[0][DATA_W-1:0];
            started = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'hF; in_data = 101'hDEAD; out_ready = 1'b1;
        #2;
        checks++;
        if (act_vec_now() !== '0)
            begin fails++; $display("FAIL reset_async: got %h want 0", act_vec_now()); end
        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (act_vec_now() !== '0)
            begin fails++; $display("FAIL reset_held: got %h want 0", act_vec_now()); end
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec())
                begin fails++; $display("FAIL reset_release c%0d: got %h want %h", i, act_vec(), exp_vec()); end
        end
    endtask

    function automatic logic [VEC_W-1:0] act_vec_now();
        return {in_ready, out_valid, out_ctrl, out_data, occupancy};
    endfunction

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_ctrl = (k == 1) ? 4'hF : CTRL_W'(k);
            in_data = DATA_W'(32'hA0 + k);
            tick();
            checks++;
            if (act_vec() !== exp_vec())
                begin fails++; $display("FAIL stream_model A%0d: got %h want %h", k, act_vec(), exp_vec()); end
            checks++;
            if ({out_valid, out_ctrl, out_data} !== {1'b1, (k == 1) ? 4'hF : CTRL_W'(k), DATA_W'(32'hA0 + k)})
                begin fails++; $display("FAIL stream_out A%0d: got %h/%h want A%0d", k, out_ctrl, out_data, k); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 4'hF; in_data = DATA_W'(32'hA1);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (act_vec() !== exp_vec())
            begin fails++; $display("FAIL bubble_model: got %h want %h", act_vec(), exp_vec()); end
        checks++;
        if ({out_valid, out_ctrl, out_data} !== {1'b0, 4'h0, DATA_W'(32'hA1)})
            begin fails++; $display("FAIL bubble_out: got %b/%h/%h want 0/0/a1", out_valid, out_ctrl, out_data); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'h3; in_data = DATA_W'(32'hA1);
        tick();
        in_ctrl = 4'h5; in_data = DATA_W'(32'hA2);
        tick();
        if (exp_ir) in_valid = 1'b0;
        checks++;
        if (act_vec() !== exp_vec())
            begin fails++; $display("FAIL skid_build: got %h want %h", act_vec(), exp_vec()); end
        checks++;
        if ({occupancy, out_data} !== {2'(CAP), DATA_W'(32'hA1)})
            begin fails++; $display("FAIL skid_occ: got %0d/%h want %0d/a1", occupancy, out_data, CAP); end
        tick();
        checks++;
        if ({act_ir, out_valid, out_data} !== {1'b0, 1'b1, DATA_W'(32'hA1)})
            begin fails++; $display("FAIL skid_stall: got ir=%b %h want ir=0 a1", act_ir, out_data); end
        out_ready = 1'b1;
        tick();
        if (in_valid && exp_ir) in_valid = 1'b0;
        checks++;
        if ({act_vec(), out_data} !== {exp_vec(), DATA_W'(32'hA2)})
            begin fails++; $display("FAIL skid_drain1: got %h want %h (a2)", act_vec(), exp_vec()); end
        tick();
        checks++;
        if ({act_vec(), act_ir, out_valid} !== {exp_vec(), 1'b1, 1'b0})
            begin fails++; $display("FAIL skid_drain2: got %h want %h", act_vec(), exp_vec()); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            in_ctrl = 4'hC; in_data = DATA_W'(32'hF0 + k);
            tick();
        end
        flush = 1'b1;
        in_valid = 1'b1; in_ctrl = 4'hE; in_data = DATA_W'(32'hB1);
        tick();
        flush = 1'b0;
        checks++;
        if (act_vec() !== exp_vec())
            begin fails++; $display("FAIL flush_model: got %h want %h", act_vec(), exp_vec()); end
        checks++;
        if ({act_ir, out_valid, out_ctrl, occupancy} !== '0)
            begin fails++; $display("FAIL flush_clear: got ir=%b v=%b c=%h occ=%0d want 0", act_ir, out_valid, out_ctrl, occupancy); end
        out_ready = 1'b1;
        in_ctrl = 4'h9; in_data = DATA_W'(32'hB2);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({act_vec(), out_valid, out_data} !== {exp_vec(), 1'b1, DATA_W'(32'hB2)})
            begin fails++; $display("FAIL flush_next: got %h want %h (b2)", act_vec(), exp_vec()); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] seq, nxt;
        int          errs;
        seq = 0; nxt = 0; errs = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 10003; i++) begin
            if (i < 10000) begin
                if (!in_valid) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_ctrl  = CTRL_W'($urandom);
                    in_data  = {5'($urandom), $urandom, $urandom, seq};
                end
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                fails++; errs++;
                if (errs < 10) $display("FAIL rand_model c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (act_ov && out_ready) begin
                checks++;
                if (act_od[31:0] !== nxt) begin
                    fails++; errs++;
                    if (errs < 10) $display("FAIL rand_order c%0d: got %0d want %0d", i, act_od[31:0], nxt);
                end
                nxt++;
            end
            checks++;
            if (occupancy > 2'(CAP)) begin
                fails++; errs++;
                if (errs < 10) $display("FAIL rand_occ c%0d: got %0d want <=%0d", i, occupancy, CAP);
            end
            if (in_valid && exp_ir) begin
                in_valid = 1'b0;
                seq++;
            end
        end
        checks++;
        if (nxt !== seq)
            begin fails++; $display("FAIL rand_count: got %0d delivered want %0d", nxt, seq); end
    endtask

    task automatic test_reset_mid();
        bit got;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            in_ctrl = 4'h7; in_data = DATA_W'(32'hD0 + k);
            tick();
        end
        in_valid = 1'b0;
        #3 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act_vec_now() !== '0)
            begin fails++; $display("FAIL rstmid_async: got %h want 0", act_vec_now()); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 4'h6; in_data = DATA_W'(32'hE1);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec())
                begin fails++; $display("FAIL rstmid_model c%0d: got %h want %h", i, act_vec(), exp_vec()); end
            if (exp_ir) got = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if ({got, in_ready, out_valid, out_ctrl, out_data} !== {1'b1, 1'b1, 1'b1, 4'h6, DATA_W'(32'hE1)})
            begin fails++; $display("FAIL rstmid_first: got ir=%b v=%b %h/%h want 1/1/6/e1", in_ready, out_valid, out_ctrl, out_data); end
        tick();
    endtask

    initial begin
        checks = 0; fails = 0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        act_ir = 1'b0; act_ov = 1'b0; act_od = '0; exp_ir = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_bubble();
        test_skid();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
